// File: rtl/sram_ctrl_32016_if.sv
// CPU-side IO bus between the 32016 address decode and the SRAM wait-state
// controller. The CPU (or bench) drives the request side; the controller
// returns read data, the completion pulse and the sticky protocol error.
interface sram_ctrl_32016_if;
    logic        sel;
    logic        io_rd;
    logic        io_wr;
    logic [18:0] io_a;
    logic [3:0]  io_be;
    logic [31:0] io_di;
    logic [31:0] io_q;
    logic        io_ready;
    logic        prot_err;

    modport master (
        output sel, io_rd, io_wr, io_a, io_be, io_di,
        input  io_q, io_ready, prot_err
    );

    modport slave (
        input  sel, io_rd, io_wr, io_a, io_be, io_di,
        output io_q, io_ready, prot_err
    );
endinterface

// File: rtl/sram_ctrl_32016.sv
// Wait-state controller for the 512K x 32 asynchronous SRAM behind the
// 32016 IO bus. Turns level-held read/write requests into sequenced
// CS/OE/WE/byte-lane strobes and a one-cycle io_ready completion pulse.
// Every SRAM-side output is a flop loaded from the next-state decode, so the
// strobes change cleanly on BCLK edges with no combinational glitches.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for sel & (io_rd | io_wr); captures addr/be/data
// RD      | CS+OE low, cnt counts read wait cycles, data sampled at 0
// WSETUP  | CS/data/be driven, WE high (address/data setup before WE)
// WPULSE  | WE low, cnt counts extra WE cycles
// WHOLD   | WE high again, CS/data/be still driven (hold after WE)
// DONE    | io_ready high for one cycle, all strobes released
// RECOVER | bus turnaround; requests ignored so a held one isn't re-taken
module sram_ctrl_32016 #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    sram_ctrl_32016_if.slave  bus,
    output logic              ram_cs_b,
    output logic              ram_oe_b,
    output logic              ram_we_b,
    output logic [3:0]        ram_be_b,
    output logic [18:0]       ram_addr,
    output logic [31:0]       ram_dout,
    output logic              ram_dout_en,
    input  logic [31:0]       ram_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_DONE, S_RECOVER
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  be_q;
    logic [31:0] io_q_r;
    logic        io_ready_r;
    logic        prot_err_r;

    logic        capture, sample, perr_set;
    logic [3:0]  be_src;
    logic        wr_any;
    logic        cs_b_d, oe_b_d, we_b_d, dout_en_d, ready_d;
    logic [3:0]  be_b_d;

    assign bus.io_q     = io_q_r;
    assign bus.io_ready = io_ready_r;
    assign bus.prot_err = prot_err_r;

    // Next-state, wait counter and the registered-output values for the next cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        sample    = 1'b0;
        perr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.sel && (bus.io_rd || bus.io_wr)) begin
                    capture  = 1'b1;
                    perr_set = bus.io_rd && bus.io_wr;
                    if (bus.io_wr) begin
                        state_nxt = S_WSETUP;
                    end else begin
                        state_nxt = S_RD;
                        cnt_nxt   = RD_CNT;
                    end
                end
            end
            S_RD: begin
                if (cnt == 4'd0) begin
                    sample    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_WSETUP: begin
                state_nxt = S_WPULSE;
                cnt_nxt   = WR_CNT;
            end
            S_WPULSE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_WHOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_WHOLD:   state_nxt = S_DONE;
            S_DONE:    state_nxt = S_RECOVER;
            S_RECOVER: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        // A write with no byte lanes still runs its full timing but never touches the RAM.
        be_src    = capture ? bus.io_be : be_q;
        wr_any    = |be_src;
        cs_b_d    = 1'b1;
        oe_b_d    = 1'b1;
        we_b_d    = 1'b1;
        be_b_d    = 4'b1111;
        dout_en_d = 1'b0;
        ready_d   = 1'b0;
        case (state_nxt)
            S_RD: begin
                cs_b_d = 1'b0;
                oe_b_d = 1'b0;
                be_b_d = 4'b0000;
            end
            S_WSETUP, S_WHOLD: begin
                cs_b_d    = ~wr_any;
                be_b_d    = ~be_src;
                dout_en_d = 1'b1;
            end
            S_WPULSE: begin
                cs_b_d    = ~wr_any;
                we_b_d    = ~wr_any;
                be_b_d    = ~be_src;
                dout_en_d = 1'b1;
            end
            S_DONE:  ready_d = 1'b1;
            default: ;
        endcase
    end

    // State, counter, captured request and all registered outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            be_q        <= 4'd0;
            io_q_r      <= 32'd0;
            io_ready_r  <= 1'b0;
            prot_err_r  <= 1'b0;
            ram_cs_b    <= 1'b1;
            ram_oe_b    <= 1'b1;
            ram_we_b    <= 1'b1;
            ram_be_b    <= 4'b1111;
            ram_addr    <= 19'd0;
            ram_dout    <= 32'd0;
            ram_dout_en <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            io_ready_r  <= ready_d;
            prot_err_r  <= prot_err_r | perr_set;
            ram_cs_b    <= cs_b_d;
            ram_oe_b    <= oe_b_d;
            ram_we_b    <= we_b_d;
            ram_be_b    <= be_b_d;
            ram_dout_en <= dout_en_d;
            if (capture) begin
                be_q     <= bus.io_be;
                ram_addr <= bus.io_a;
                ram_dout <= bus.io_di;
            end
            if (sample) begin
                io_q_r <= ram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl_32016.sv
// Bench for sram_ctrl_32016: three instances (wait states 1/1, 0/0, 15/15)
// share the request lines, each with its own sel. Requests push the expected
// ready cycle, io_q and prot_err into a per-instance queue; a monitor per
// instance pops and compares whenever io_ready is seen.
module tb_sram_ctrl_32016;

    typedef struct {
        int          cyc;
        logic [31:0] q;
        logic        pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [2:0]  sel_v = '0;
    logic        rd_v = 1'b0, wr_v = 1'b0;
    logic [18:0] a_v = '0;
    logic [3:0]  be_v = '0;
    logic [31:0] di_v = '0;
    logic [31:0] din_v = '0;

    logic        cs_b[3], oe_b[3], we_b[3], den[3];
    logic [3:0]  be_b[3];
    logic [18:0] addr[3];
    logic [31:0] dout[3];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q0[$], q1[$], q2[$];

    // strobe statistics of instance 0 (running totals) and of cs on all instances
    int          mon[6];
    int          base[6];
    logic        cs_prev = 1'b1, we_prev = 1'b1;
    int          cs_fall_cyc = -1, cs_last_cyc = -1, we_fall_cyc = -1, we_last_cyc = -1, den_last_cyc = -1;
    logic [18:0] cap_addr = '0;
    logic [3:0]  cap_be = '0;
    logic [31:0] cap_dout = '0;

    sram_ctrl_32016_if b0 ();
    sram_ctrl_32016_if b1 ();
    sram_ctrl_32016_if b2 ();

    assign b0.sel = sel_v[0];
    assign b1.sel = sel_v[1];
    assign b2.sel = sel_v[2];
    assign b0.io_rd = rd_v;  assign b1.io_rd = rd_v;  assign b2.io_rd = rd_v;
    assign b0.io_wr = wr_v;  assign b1.io_wr = wr_v;  assign b2.io_wr = wr_v;
    assign b0.io_a  = a_v;   assign b1.io_a  = a_v;   assign b2.io_a  = a_v;
    assign b0.io_be = be_v;  assign b1.io_be = be_v;  assign b2.io_be = be_v;
    assign b0.io_di = di_v;  assign b1.io_di = di_v;  assign b2.io_di = di_v;

    wire [2:0] rdy_w = {b2.io_ready, b1.io_ready, b0.io_ready};

    sram_ctrl_32016 #(.RD_WAIT(1), .WR_WAIT(1)) dut0 (
        .clk(clk), .rst_b(rst_b), .bus(b0),
        .ram_cs_b(cs_b[0]), .ram_oe_b(oe_b[0]), .ram_we_b(we_b[0]), .ram_be_b(be_b[0]),
        .ram_addr(addr[0]), .ram_dout(dout[0]), .ram_dout_en(den[0]), .ram_din(din_v)
    );
    sram_ctrl_32016 #(.RD_WAIT(0), .WR_WAIT(0)) dut1 (
        .clk(clk), .rst_b(rst_b), .bus(b1),
        .ram_cs_b(cs_b[1]), .ram_oe_b(oe_b[1]), .ram_we_b(we_b[1]), .ram_be_b(be_b[1]),
        .ram_addr(addr[1]), .ram_dout(dout[1]), .ram_dout_en(den[1]), .ram_din(din_v)
    );
    sram_ctrl_32016 #(.RD_WAIT(15), .WR_WAIT(15)) dut2 (
        .clk(clk), .rst_b(rst_b), .bus(b2),
        .ram_cs_b(cs_b[2]), .ram_oe_b(oe_b[2]), .ram_we_b(we_b[2]), .ram_be_b(be_b[2]),
        .ram_addr(addr[2]), .ram_dout(dout[2]), .ram_dout_en(den[2]), .ram_din(din_v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    function automatic void score(int d, logic [31:0] q, logic pe);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ready: dut%0d got ready at cycle %0d, expected none", d, cyc);
            return;
        end
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("ready_cycle_dut%0d", d), 64'(cyc), 64'(e.cyc));
        chk($sformatf("io_q_dut%0d", d), 64'(q), 64'(e.q));
        chk($sformatf("prot_err_dut%0d", d), 64'(pe), 64'(e.pe));
    endfunction

    // scoreboard monitors
    always @(negedge clk) if (b0.io_ready === 1'b1) score(0, b0.io_q, b0.prot_err);
    always @(negedge clk) if (b1.io_ready === 1'b1) score(1, b1.io_q, b1.prot_err);
    always @(negedge clk) if (b2.io_ready === 1'b1) score(2, b2.io_q, b2.prot_err);

    // strobe observation
    always @(negedge clk) begin
        if (!cs_b[0]) begin
            mon[0]++;
            cs_last_cyc = cyc;
            cap_addr = addr[0];
            cap_be   = be_b[0];
            cap_dout = dout[0];
            if (cs_prev) begin
                mon[3]++;
                cs_fall_cyc = cyc;
            end
        end
        if (!oe_b[0]) mon[1]++;
        if (!we_b[0]) begin
            mon[2]++;
            we_last_cyc = cyc;
            if (we_prev) we_fall_cyc = cyc;
        end
        if (den[0]) den_last_cyc = cyc;
        if (!cs_b[1]) mon[4]++;
        if (!cs_b[2]) mon[5]++;
        cs_prev = cs_b[0];
        we_prev = we_b[0];
    end

    function automatic int delta(int i);
        return mon[i] - base[i];
    endfunction

    task automatic req(input int d, input logic rd, input logic wr, input logic [18:0] a,
                       input logic [3:0] be, input logic [31:0] di, input int lat,
                       input logic [31:0] eq, input logic epe, input int hold, output int e0);
        exp_t e;
        bit   got;
        @(negedge clk);
        sel_v = 3'b001 << d;
        rd_v = rd; wr_v = wr; a_v = a; be_v = be; di_v = di;
        e0 = cyc + 1;
        e.cyc = e0 + lat; e.q = eq; e.pe = epe;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (rdy_w[d]) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: dut%0d no ready within 40 cycles of cycle %0d", d, e0);
        end
        repeat (hold) @(negedge clk);
        sel_v = '0; rd_v = 1'b0; wr_v = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        int e0;
        foreach (mon[i]) mon[i] = 0;
        base = mon;
        din_v = 32'hDEADBEEF;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_b", 64'(cs_b[0]), 64'd1);
        chk("rst_oe_b", 64'(oe_b[0]), 64'd1);
        chk("rst_we_b", 64'(we_b[0]), 64'd1);
        chk("rst_be_b", 64'(be_b[0]), 64'hF);
        chk("rst_dout_en", 64'(den[0]), 64'd0);
        chk("rst_ready", 64'(b0.io_ready), 64'd0);
        chk("rst_io_q", 64'(b0.io_q), 64'd0);
        chk("rst_addr", 64'(addr[0]), 64'd0);
        chk("rst_dout", 64'(dout[0]), 64'd0);
        chk("rst_prot_err", 64'(b0.prot_err), 64'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // read, RD_WAIT=1
        base = mon;
        req(0, 1'b1, 1'b0, 19'h12345, 4'hF, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, e0);
        chk("rd_oe_low_cycles", 64'(delta(1)), 64'd2);
        chk("rd_cs_low_cycles", 64'(delta(0)), 64'd2);
        chk("rd_addr", 64'(cap_addr), 64'h12345);
        chk("rd_be_b", 64'(cap_be), 64'h0);
        chk("rd_cs_fall", 64'(cs_fall_cyc), 64'(e0));

        // write, WR_WAIT=1, be=0101
        base = mon;
        req(0, 1'b0, 1'b1, 19'h00ABC, 4'b0101, 32'hCAFEF00D, 4, 32'hDEADBEEF, 1'b0, 0, e0);
        chk("wr_be_b", 64'(cap_be), 64'b1010);
        chk("wr_dout", 64'(cap_dout), 64'hCAFEF00D);
        chk("wr_addr", 64'(cap_addr), 64'h00ABC);
        chk("wr_we_low_cycles", 64'(delta(2)), 64'd2);
        chk("wr_cs_fall", 64'(cs_fall_cyc), 64'(e0));
        chk("wr_we_fall", 64'(we_fall_cyc), 64'(e0 + 1));
        chk("wr_we_last", 64'(we_last_cyc), 64'(e0 + 2));
        chk("wr_cs_last", 64'(cs_last_cyc), 64'(e0 + 3));
        chk("wr_dout_en_last", 64'(den_last_cyc), 64'(e0 + 3));

        // held read: request kept through the DONE and RECOVER cycles
        din_v = 32'h0BADF00D;
        base = mon;
        req(0, 1'b1, 1'b0, 19'h7FFFF, 4'h0, 32'h0, 2, 32'h0BADF00D, 1'b0, 2, e0);
        chk("held_access_count", 64'(delta(3)), 64'd1);
        req(0, 1'b1, 1'b0, 19'h00001, 4'h0, 32'h0, 2, 32'h0BADF00D, 1'b0, 0, e0);
        chk("rerequest_access_count", 64'(delta(3)), 64'd2);

        // collision with zero byte enables
        base = mon;
        req(0, 1'b1, 1'b1, 19'h00002, 4'b0000, 32'h11111111, 4, 32'h0BADF00D, 1'b1, 0, e0);
        chk("zbe_cs_low_cycles", 64'(delta(0)), 64'd0);
        chk("zbe_we_low_cycles", 64'(delta(2)), 64'd0);
        chk("prot_err_set", 64'(b0.prot_err), 64'd1);
        din_v = 32'h5A5AA5A5;
        req(0, 1'b1, 1'b0, 19'h00003, 4'h0, 32'h0, 2, 32'h5A5AA5A5, 1'b1, 0, e0);
        chk("prot_err_sticky", 64'(b0.prot_err), 64'd1);

        // parameter sweep; dut0 sees sel=0 meanwhile
        din_v = 32'h0F1E2D3C;
        base = mon;
        req(1, 1'b1, 1'b0, 19'h00010, 4'hF, 32'h0, 1, 32'h0F1E2D3C, 1'b0, 0, e0);
        req(1, 1'b0, 1'b1, 19'h00011, 4'hF, 32'h22222222, 3, 32'h0F1E2D3C, 1'b0, 0, e0);
        req(2, 1'b1, 1'b0, 19'h00020, 4'hF, 32'h0, 16, 32'h0F1E2D3C, 1'b0, 0, e0);
        req(2, 1'b0, 1'b1, 19'h00021, 4'hF, 32'h33333333, 18, 32'h0F1E2D3C, 1'b0, 0, e0);
        chk("unselected_dut0_cs", 64'(delta(0)), 64'd0);

        // requests with sel low on every instance
        @(negedge clk);
        base = mon;
        rd_v = 1'b1; wr_v = 1'b1; be_v = 4'hF;
        repeat (25) @(negedge clk);
        #1;
        rd_v = 1'b0; wr_v = 1'b0;
        chk("sel0_cs_dut0", 64'(delta(0)), 64'd0);
        chk("sel0_cs_dut1", 64'(delta(4)), 64'd0);
        chk("sel0_cs_dut2", 64'(delta(5)), 64'd0);

        // async reset in the middle of WPULSE
        @(negedge clk);
        sel_v = 3'b001; wr_v = 1'b1; a_v = 19'h00055; be_v = 4'hF; di_v = 32'h44444444;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_rst_we_low", 64'(we_b[0]), 64'd0);
        rst_b = 1'b0;
        #1;
        chk("rst_mid_we_b", 64'(we_b[0]), 64'd1);
        chk("rst_mid_cs_b", 64'(cs_b[0]), 64'd1);
        chk("rst_mid_dout_en", 64'(den[0]), 64'd0);
        chk("rst_mid_ready", 64'(b0.io_ready), 64'd0);
        sel_v = '0; wr_v = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("post_rst_addr", 64'(addr[0]), 64'd0);
        chk("post_rst_io_q", 64'(b0.io_q), 64'd0);
        chk("post_rst_prot_err", 64'(b0.prot_err), 64'd0);
        din_v = 32'h13579BDF;
        req(0, 1'b1, 1'b0, 19'h00066, 4'h0, 32'h0, 2, 32'h13579BDF, 1'b0, 0, e0);

        repeat (5) @(negedge clk);
        chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
